// File: rtl/op_sequencer.sv
// op_sequencer: instruction-issue stage in front of the register file and FU datapath.
// It fetches one coefficient-vector instruction at a time from a synchronous
// instruction memory and decodes it into RF operation controls. It then issues
// the operation with a registered one-cycle start pulse and waits for the
// final writeback beat before it fetches the next instruction.
module op_sequencer #(
  parameter int NREG       = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int REGW       = $clog2(NREG),
  parameter int PCW        = $clog2(IMEM_DEPTH),
  parameter int INSTR_W    = 3 + 3 * REGW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic [PCW-1:0]     imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               rf_ready,
  output logic               start_operation,
  output logic               use_source1,
  output logic [REGW-1:0]    source0_register_index,
  output logic [REGW-1:0]    source1_register_index,
  output logic [REGW-1:0]    destination_register_index,
  output logic [1:0]         fu_sel,
  input  logic               wb_valid,
  input  logic               wb_last,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [15:0]        op_count
);

  // Opcode encodings carried in the top three bits of every instruction word.
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_NTT  = 3'd3;
  localparam logic [2:0] OP_HALT = 3'd7;

  // Functional-unit select values presented to the datapath.
  localparam logic [1:0] FU_ADD = 2'd0;
  localparam logic [1:0] FU_MUL = 2'd1;
  localparam logic [1:0] FU_NTT = 2'd2;

  localparam logic [PCW-1:0] LAST_PC = PCW'(IMEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WAIT_RF,
    S_WAIT_DONE,
    S_DONE,
    S_ERROR
  } state_t;

  // Architectural state, all registered.
  state_t           state_q,  state_d;
  logic [PCW-1:0]   pc_q,     pc_d;
  logic             start_q,  start_d;
  logic             use1_q,   use1_d;
  logic [REGW-1:0]  src0_q,   src0_d;
  logic [REGW-1:0]  src1_q,   src1_d;
  logic [REGW-1:0]  dst_q,    dst_d;
  logic [1:0]       fu_q,     fu_d;
  logic             done_q,   done_d;
  logic             error_q,  error_d;
  logic [15:0]      count_q,  count_d;

  // Instruction fields: {opcode, dst, src0, src1} from MSB to LSB.
  logic [2:0]       opcode;
  logic [REGW-1:0]  field_dst;
  logic [REGW-1:0]  field_src0;
  logic [REGW-1:0]  field_src1;

  assign opcode     = imem_rdata[INSTR_W-1 -: 3];
  assign field_dst  = imem_rdata[3*REGW-1 -: REGW];
  assign field_src0 = imem_rdata[2*REGW-1 -: REGW];
  assign field_src1 = imem_rdata[REGW-1:0];

  // Helpers shared by the NOP path and the retire path.
  logic             at_last_pc;
  logic [PCW-1:0]   pc_plus_one;
  logic [15:0]      count_plus_one;
  logic             retire_beat;

  assign at_last_pc     = (pc_q == LAST_PC);
  assign pc_plus_one    = pc_q + PCW'(1);
  assign count_plus_one = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
  assign retire_beat    = wb_valid & wb_last;

  // Next-state and next-register computation; every register holds by default.
  // The start pulse defaults low, so it can only be high for one cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    start_d = 1'b0;
    use1_d  = use1_q;
    src0_d  = src0_q;
    src1_d  = src1_q;
    dst_d   = dst_q;
    fu_d    = fu_q;
    done_d  = done_q;
    error_d = error_q;
    count_d = count_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (run) begin
          pc_d    = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          count_d = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        state_d = S_DECODE;
      end

      S_DECODE: begin
        case (opcode)
          OP_NOP: begin
            if (at_last_pc) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              pc_d    = pc_plus_one;
              state_d = S_FETCH;
            end
          end
          OP_HALT: begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
          OP_ADD, OP_MUL: begin
            dst_d   = field_dst;
            src0_d  = field_src0;
            src1_d  = field_src1;
            use1_d  = 1'b1;
            fu_d    = (opcode == OP_ADD) ? FU_ADD : FU_MUL;
            state_d = S_WAIT_RF;
          end
          OP_NTT: begin
            dst_d   = field_dst;
            src0_d  = field_src0;
            src1_d  = '0;
            use1_d  = 1'b0;
            fu_d    = FU_NTT;
            state_d = S_WAIT_RF;
          end
          default: begin
            error_d = 1'b1;
            state_d = S_ERROR;
          end
        endcase
      end

      S_WAIT_RF: begin
        if (rf_ready) begin
          start_d = 1'b1;
          state_d = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (retire_beat) begin
          count_d = count_plus_one;
          if (at_last_pc) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            pc_d    = pc_plus_one;
            state_d = S_FETCH;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with asynchronous clear so reset wins even mid-operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      start_q <= 1'b0;
      use1_q  <= 1'b0;
      src0_q  <= '0;
      src1_q  <= '0;
      dst_q   <= '0;
      fu_q    <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      start_q <= start_d;
      use1_q  <= use1_d;
      src0_q  <= src0_d;
      src1_q  <= src1_d;
      dst_q   <= dst_d;
      fu_q    <= fu_d;
      done_q  <= done_d;
      error_q <= error_d;
      count_q <= count_d;
    end
  end

  // All outputs come straight from registers, so no input reaches them combinationally.
  assign imem_addr                  = pc_q;
  assign start_operation            = start_q;
  assign use_source1                = use1_q;
  assign source0_register_index     = src0_q;
  assign source1_register_index     = src1_q;
  assign destination_register_index = dst_q;
  assign fu_sel                     = fu_q;
  assign done                       = done_q;
  assign error                      = error_q;
  assign op_count                   = count_q;
  assign busy = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);

endmodule
